// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution result writer.
// Holds the pixel post-processing rule used by the S2 stage.
package conv_pkg;

    localparam int unsigned CALC_W = 24;
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned SUM_W  = CALC_W + 1;

    typedef enum logic {
        IDLE,
        RUN
    } wr_state_t;

    // ReLU, arithmetic-free right shift, then saturate to an unsigned pixel.
    function automatic logic [PIX_W-1:0] relu_shift_sat(
        input logic signed [SUM_W-1:0] sum,
        input logic        [3:0]       shift
    );
        logic [SUM_W-1:0] w_r;
        logic [PIX_W-1:0] w_pix;
        w_r = $unsigned(sum) >> shift;
        if (sum[SUM_W-1]) begin
            w_pix = '0;
        end else if (|w_r[SUM_W-1:PIX_W]) begin
            w_pix = '1;
        end else begin
            w_pix = w_r[PIX_W-1:0];
        end
        return w_pix;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO with power-of-two depth; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module result_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB distinguishes full from empty.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/conv_result_writer.sv
// Captures convolution results, applies bias/ReLU/shift/saturate in two stages,
// buffers them and streams them into the output feature-map RAM.
module conv_result_writer
    import conv_pkg::*;
#(
    parameter int unsigned OUT_ADDR_W = 10,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned N_RESULTS  = 900
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic [OUT_ADDR_W-1:0] s_out_addr,
    input  logic [CALC_W-1:0]     bias,
    input  logic [3:0]            shift,
    input  logic                  done,
    input  logic [CALC_W-1:0]     calc_data,
    input  logic                  ram_grant,
    output logic [OUT_ADDR_W-1:0] o_addr,
    output logic [PIX_W-1:0]      o_data,
    output logic                  o_we,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overflow
);

    localparam int unsigned CNT_W = $clog2(N_RESULTS + 1);
    localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_RESULTS);

    wr_state_t              r_state;
    logic [OUT_ADDR_W-1:0]  r_addr_cur;
    logic [CALC_W-1:0]      r_bias;
    logic [3:0]             r_shift;
    logic [CNT_W-1:0]       r_acc_cnt;
    logic [CNT_W-1:0]       r_wr_cnt;
    logic                   r_s1_valid;
    logic signed [SUM_W-1:0] r_s1_sum;
    logic                   r_s2_valid;
    logic [PIX_W-1:0]       r_s2_pix;
    logic [OUT_ADDR_W-1:0]  r_addr;
    logic [PIX_W-1:0]       r_data;
    logic                   r_we;
    logic                   r_frame_done;
    logic                   r_overflow;

    logic                   w_run;
    logic                   w_accept;
    logic                   w_reject;
    logic                   w_pop;
    logic                   w_push_drop;
    logic                   w_frame_end;
    logic                   w_full;
    logic                   w_empty;
    logic [PIX_W-1:0]       w_head;

    assign w_run       = (r_state == RUN);
    assign w_accept    = done & w_run & (r_acc_cnt < N_LAST);
    assign w_reject    = done & ~w_accept;
    assign w_pop       = ~w_empty & ram_grant & w_run;
    assign w_push_drop = r_s2_valid & w_full & ~w_pop;
    assign w_frame_end = w_run & (r_wr_cnt == N_LAST);

    result_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_s2_valid),
        .i_data  (r_s2_pix),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // S1 adds the bias at 25 bits; S2 post-processes into a pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_pix   <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_sum <= {calc_data[CALC_W-1], calc_data} + {r_bias[CALC_W-1], r_bias};
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_pix <= relu_shift_sat(r_s1_sum, r_shift);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_addr_cur   <= '0;
            r_bias       <= '0;
            r_shift      <= '0;
            r_acc_cnt    <= '0;
            r_wr_cnt     <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_we         <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_we         <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (frame_start) begin
                        r_addr_cur <= s_out_addr;
                        r_bias     <= bias;
                        r_shift    <= shift;
                        r_acc_cnt  <= '0;
                        r_wr_cnt   <= '0;
                        r_overflow <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    if (w_frame_end) begin
                        r_frame_done <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (w_accept) r_acc_cnt <= r_acc_cnt + CNT_W'(1);
            if (w_pop) begin
                r_we       <= 1'b1;
                r_data     <= w_head;
                r_addr     <= r_addr_cur;
                r_addr_cur <= r_addr_cur + OUT_ADDR_W'(1);
                r_wr_cnt   <= r_wr_cnt + CNT_W'(1);
            end
            // A late error in the frame_start cycle still leaves the flag set.
            if (w_reject || w_push_drop) r_overflow <= 1'b1;
        end
    end

    assign o_addr     = r_addr;
    assign o_data     = r_data;
    assign o_we       = r_we;
    assign busy       = w_run;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_conv_result_writer.sv
// Randomized scoreboard bench: a queue-based frame model predicts RAM writes
// and status flags; a negedge monitor compares them against the DUT.
module tb_conv_result_writer;

    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned NRES  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic [AW-1:0] s_out_addr = '0;
    logic [23:0]   bias = '0;
    logic [3:0]    shift = '0;
    logic          done = 1'b0;
    logic [23:0]   calc_data = '0;
    logic          ram_grant = 1'b0;
    logic [AW-1:0] o_addr;
    logic [7:0]    o_data;
    logic          o_we;
    logic          busy;
    logic          frame_done;
    logic          overflow;

    int n_vec = 0;
    int n_err = 0;

    conv_result_writer #(
        .OUT_ADDR_W (AW),
        .FIFO_DEPTH (DEPTH),
        .N_RESULTS  (NRES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .s_out_addr  (s_out_addr),
        .bias        (bias),
        .shift       (shift),
        .done        (done),
        .calc_data   (calc_data),
        .ram_grant   (ram_grant),
        .o_addr      (o_addr),
        .o_data      (o_data),
        .o_we        (o_we),
        .busy        (busy),
        .frame_done  (frame_done),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit m_run = 0;
    bit m_ovf = 0;
    bit m_fd  = 0;
    int m_acc = 0;
    int m_wr  = 0;
    int m_cur = 0;
    int m_bias = 0;
    int m_shift = 0;
    int cyc = 0;
    int m_fifo[$];
    int pipe_val[$];
    int pipe_due[$];
    int exp_addr[$];
    int exp_data[$];

    function automatic int ref_pix(input int c, input int b, input int sh);
        int s;
        s = c + b;
        if (s < 0) return 0;
        s = s / (1 << sh);
        return (s > 255) ? 255 : s;
    endfunction

    function automatic int rnd_calc();
        logic signed [23:0] t;
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 6000)) - 1500;
        t = 24'($urandom);
        return int'(t);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit was_run;
        bit do_pop;
        bit do_push;
        bit fd_next;
        int pv;
        if (!rst_n) begin
            m_run = 0;
            m_ovf = 0;
            m_fd  = 0;
            m_acc = 0;
            m_wr  = 0;
            m_cur = 0;
            m_fifo.delete();
            pipe_val.delete();
            pipe_due.delete();
            exp_addr.delete();
            exp_data.delete();
        end else begin
            cyc++;
            was_run = m_run;
            m_fd    = 0;
            fd_next = was_run && (m_wr == NRES);
            do_pop  = was_run && (m_fifo.size() > 0) && ram_grant;
            do_push = (pipe_due.size() > 0) && (pipe_due[0] == cyc);
            pv = 0;
            if (do_push) begin
                pv = pipe_val.pop_front();
                void'(pipe_due.pop_front());
            end
            if (do_pop) begin
                exp_data.push_back(m_fifo.pop_front());
                exp_addr.push_back(m_cur);
                m_cur = (m_cur + 1) % (1 << AW);
                m_wr++;
            end
            if (do_push) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back(pv);
                else m_ovf = 1;
            end
            if (!was_run && frame_start) begin
                m_cur   = int'(s_out_addr);
                m_bias  = int'($signed(bias));
                m_shift = int'(shift);
                m_acc   = 0;
                m_wr    = 0;
                m_ovf   = 0;
                m_run   = 1;
            end else if (fd_next) begin
                m_fd  = 1;
                m_run = 0;
            end
            if (done) begin
                if (was_run && m_acc < NRES) begin
                    m_acc++;
                    pipe_val.push_back(ref_pix(int'($signed(calc_data)), m_bias, m_shift));
                    pipe_due.push_back(cyc + 2);
                end else begin
                    m_ovf = 1;
                end
            end
        end
    end

    // Monitor: a write predicted at an edge must be visible by the following negedge.
    always @(negedge clk) begin
        int ea;
        int ed;
        bit exp_we;
        if (rst_n) begin
            exp_we = (exp_addr.size() > 0);
            n_vec++;
            if (o_we !== exp_we) begin
                n_err++;
                $display("FAIL write_strobe: o_we=%b, required %b (t=%0t)", o_we, exp_we, $time);
            end
            if (exp_we) begin
                ea = exp_addr.pop_front();
                ed = exp_data.pop_front();
                if (o_we === 1'b1) begin
                    n_vec++;
                    if (o_addr !== ea[AW-1:0] || o_data !== ed[7:0]) begin
                        n_err++;
                        $display("FAIL write_data: addr=%0d data=%0d, required addr=%0d data=%0d",
                                 o_addr, o_data, ea, ed);
                    end
                end
            end
            n_vec++;
            if (busy !== m_run || frame_done !== m_fd || overflow !== m_ovf) begin
                n_err++;
                $display("FAIL status: busy=%b frame_done=%b overflow=%b, required %b %b %b (t=%0t)",
                         busy, frame_done, overflow, m_run, m_fd, m_ovf, $time);
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        done = 1'b0;
        frame_start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start_frame(input int base, input int b, input int sh);
        frame_start = 1'b1;
        s_out_addr  = base[AW-1:0];
        bias        = b[23:0];
        shift       = sh[3:0];
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic send(input int v);
        done = 1'b1;
        calc_data = v[23:0];
        @(negedge clk);
        done = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while ((m_run || exp_addr.size() > 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        n_vec++;
        if (busy !== m_run) begin
            n_err++;
            $display("FAIL %s_end: busy=%b after %0d cycles, required %b", nm, busy, k, m_run);
        end
        // A frame that lost results never completes; recover with reset.
        if (m_run) do_reset();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nd;
        do_reset();
        n_vec++;
        if (o_we !== 1'b0 || o_addr !== '0 || o_data !== '0 || busy !== 1'b0 ||
            frame_done !== 1'b0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: we=%b addr=%0d data=%0d busy=%b fd=%b ovf=%b, required all 0",
                     o_we, o_addr, o_data, busy, frame_done, overflow);
        end

        // Basic frame
        ram_grant = 1'b1;
        start_frame(16, 0, 0);
        send(5); send(300); send(-7); send(255);
        send(1000); send(0); send(128); send(-1);
        wait_idle("basic_frame");

        // Bias and shift
        start_frame($urandom_range(0, 1023), -1000, 4);
        send(5000);
        @(negedge clk);
        send(500);
        for (int i = 0; i < 6; i++) begin
            ram_grant = ($urandom_range(0, 3) != 0);
            send(rnd_calc());
        end
        ram_grant = 1'b1;
        wait_idle("bias_shift");

        // Fill the FIFO, then push and pop together; addresses wrap past 1023
        ram_grant = 1'b0;
        start_frame(1022, int'($urandom_range(0, 200)) - 100, 0);
        for (int i = 0; i < 8; i++) begin
            ram_grant = (i >= 6);
            send(rnd_calc());
        end
        ram_grant = 1'b1;
        wait_idle("stream_wrap");

        // Backpressure: 6 results into a 4-entry FIFO
        ram_grant = 1'b0;
        start_frame(256, 0, 0);
        for (int i = 0; i < 6; i++) send(int'($urandom_range(0, 255)));
        repeat (6) @(negedge clk);
        ram_grant = 1'b1;
        repeat (8) @(negedge clk);
        n_vec++;
        if (overflow !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL backpressure: overflow=%b busy=%b, required 1 1", overflow, busy);
        end

        // Reset while a write is on the RAM port
        ram_grant = 1'b0;
        send(11);
        send(22);
        repeat (3) @(negedge clk);
        ram_grant = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (o_we !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: o_we=%b busy=%b, required 0 0", o_we, busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Spurious done in IDLE
        @(negedge clk);
        send(77);
        repeat (4) @(negedge clk);
        n_vec++;
        if (overflow !== 1'b1 || o_we !== 1'b0) begin
            n_err++;
            $display("FAIL idle_done: overflow=%b o_we=%b, required 1 0", overflow, o_we);
        end

        // Random frames with random grant, gaps, extra results and ignored frame_start
        for (int f = 0; f < 8; f++) begin
            start_frame($urandom_range(0, 1023), int'($urandom_range(0, 4000)) - 2000,
                        $urandom_range(0, 15));
            nd = $urandom_range(8, 10);
            for (int i = 0; i < nd; i++) begin
                ram_grant   = ($urandom_range(0, 3) != 0);
                frame_start = (i == 2);
                if (i == 2) s_out_addr = AW'($urandom);
                if ($urandom_range(0, 2) == 0) @(negedge clk);
                send(rnd_calc());
                frame_start = 1'b0;
            end
            ram_grant = 1'b1;
            wait_idle("random_frame");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
